// File: rtl/l1_l2_refill_arbiter.sv
// Shares one L2 port between I-cache refills and D-cache refills/writebacks.
// One transaction in flight at a time; round-robin grant; watchdog on the L2 response.
module l1_l2_refill_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr_i,
  output logic                  ic_req_ready_o,
  output logic                  ic_resp_valid_o,
  output logic [LINE_WIDTH-1:0] ic_resp_data_o,
  output logic                  ic_resp_error_o,
  input  logic                  ic_resp_ready_i,
  input  logic                  dc_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] dc_req_addr_i,
  input  logic                  dc_req_we_i,
  input  logic [LINE_WIDTH-1:0] dc_req_wdata_i,
  output logic                  dc_req_ready_o,
  output logic                  dc_resp_valid_o,
  output logic [LINE_WIDTH-1:0] dc_resp_data_o,
  output logic                  dc_resp_error_o,
  input  logic                  dc_resp_ready_i,
  output logic                  l2_req_valid_o,
  output logic [ADDR_WIDTH-1:0] l2_req_addr_o,
  output logic                  l2_req_we_o,
  output logic [LINE_WIDTH-1:0] l2_req_wdata_o,
  input  logic                  l2_req_ready_i,
  input  logic                  l2_resp_valid_i,
  input  logic [LINE_WIDTH-1:0] l2_resp_data_i,
  input  logic                  l2_resp_error_i,
  output logic                  l2_resp_ready_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;      // 1 = D-cache
  logic                  rr_last_q, rr_last_d;  // 1 = D-cache
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  rerr_q, rerr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  to_pend_q, to_pend_d;
  logic                  gnt_ic, gnt_dc, resp_hs;

  assign gnt_ic = ic_req_valid_i && (!dc_req_valid_i || rr_last_q);
  assign gnt_dc = dc_req_valid_i && (!ic_req_valid_i || !rr_last_q);
  assign ic_req_ready_o = (state_q == IDLE) && gnt_ic;
  assign dc_req_ready_o = (state_q == IDLE) && gnt_dc;
  assign resp_hs = (state_q == RESP) && (owner_q ? dc_resp_ready_i : ic_resp_ready_i);

  // Handshake outputs decode straight from flopped state: no L2 input reaches an L2 output.
  assign l2_req_valid_o  = (state_q == REQ);
  assign l2_resp_ready_o = (state_q == WAIT);
  assign l2_req_addr_o   = addr_q;
  assign l2_req_we_o     = we_q;
  assign l2_req_wdata_o  = wdata_q;
  assign ic_resp_valid_o = (state_q == RESP) && !owner_q;
  assign dc_resp_valid_o = (state_q == RESP) && owner_q;
  assign ic_resp_data_o  = owner_q ? '0 : rdata_q;
  assign dc_resp_data_o  = owner_q ? rdata_q : '0;
  assign ic_resp_error_o = !owner_q && rerr_q;
  assign dc_resp_error_o = owner_q && rerr_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    cnt_d     = cnt_q;
    to_pend_d = to_pend_q;
    case (state_q)
      IDLE: begin
        if (gnt_ic) begin
          owner_d = 1'b0;
          addr_d  = {ic_req_addr_i[ADDR_WIDTH-1:6], 6'b0};
          we_d    = 1'b0;
          wdata_d = '0;
          state_d = REQ;
        end else if (gnt_dc) begin
          owner_d = 1'b1;
          addr_d  = {dc_req_addr_i[ADDR_WIDTH-1:6], 6'b0};
          we_d    = dc_req_we_i;
          wdata_d = dc_req_wdata_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (l2_req_ready_i) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A response landing on the timeout cycle still wins.
        if (l2_resp_valid_i) begin
          rdata_d   = we_q ? '0 : l2_resp_data_i;
          rerr_d    = l2_resp_error_i;
          to_pend_d = 1'b0;
          state_d   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d   = '0;
          rerr_d    = 1'b1;
          to_pend_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (resp_hs) begin
          rr_last_d = owner_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
      cnt_q     <= '0;
      to_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
      cnt_q     <= cnt_d;
      to_pend_q <= to_pend_d;
    end
  end

`ifndef SYNTHESIS
  // A timed-out response showing up outside WAIT breaks the L2 protocol.
  always_ff @(posedge clk)
    if (rst_n && to_pend_q && state_q != WAIT)
      assert (!l2_resp_valid_i) else $error("late L2 response after timeout");
`endif
endmodule

// File: tb/tb_l1_l2_refill_arbiter.sv
// Directed bench for l1_l2_refill_arbiter with a response scoreboard.
module tb_l1_l2_refill_arbiter;
  localparam int AW = 32;
  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ic_req_valid_i, ic_req_ready_o, ic_resp_valid_o, ic_resp_error_o, ic_resp_ready_i;
  logic [AW-1:0] ic_req_addr_i;
  logic [LW-1:0] ic_resp_data_o;
  logic          dc_req_valid_i, dc_req_we_i, dc_req_ready_o, dc_resp_valid_o, dc_resp_error_o, dc_resp_ready_i;
  logic [AW-1:0] dc_req_addr_i;
  logic [LW-1:0] dc_req_wdata_i, dc_resp_data_o;
  logic          l2_req_valid_o, l2_req_we_o, l2_req_ready_i, l2_resp_valid_i, l2_resp_error_i, l2_resp_ready_o;
  logic [AW-1:0] l2_req_addr_o;
  logic [LW-1:0] l2_req_wdata_o, l2_resp_data_i;

  typedef struct {
    logic          dc;
    logic [LW-1:0] data;
    logic          err;
  } resp_t;
  resp_t sb[$];

  int checks = 0;
  int errors = 0;

  localparam logic [LW-1:0] PAT_A5 = {64{8'hA5}};
  localparam logic [LW-1:0] PAT_3C = {64{8'h3C}};
  localparam logic [LW-1:0] PAT_WB = {16{32'hDEADBEEF}};

  l1_l2_refill_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i), .ic_req_ready_o(ic_req_ready_o),
    .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_data_o(ic_resp_data_o), .ic_resp_error_o(ic_resp_error_o),
    .ic_resp_ready_i(ic_resp_ready_i),
    .dc_req_valid_i(dc_req_valid_i), .dc_req_addr_i(dc_req_addr_i), .dc_req_we_i(dc_req_we_i),
    .dc_req_wdata_i(dc_req_wdata_i), .dc_req_ready_o(dc_req_ready_o),
    .dc_resp_valid_o(dc_resp_valid_o), .dc_resp_data_o(dc_resp_data_o), .dc_resp_error_o(dc_resp_error_o),
    .dc_resp_ready_i(dc_resp_ready_i),
    .l2_req_valid_o(l2_req_valid_o), .l2_req_addr_o(l2_req_addr_o), .l2_req_we_o(l2_req_we_o),
    .l2_req_wdata_o(l2_req_wdata_o), .l2_req_ready_i(l2_req_ready_i),
    .l2_resp_valid_i(l2_resp_valid_i), .l2_resp_data_i(l2_resp_data_i), .l2_resp_error_i(l2_resp_error_i),
    .l2_resp_ready_o(l2_resp_ready_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a response, compares it to the scoreboard head, then handshakes.
  task automatic wait_resp(input string tag);
    int    n = 0;
    resp_t e;
    while (!(ic_resp_valid_o || dc_resp_valid_o) && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_arrived"}, (n < 100), 1);
    chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
    if (n < 100 && sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_owner_dc"}, dc_resp_valid_o, e.dc);
      chk({tag, "_other_valid"}, e.dc ? ic_resp_valid_o : dc_resp_valid_o, 0);
      chk({tag, "_data"}, e.dc ? dc_resp_data_o : ic_resp_data_o, e.data);
      chk({tag, "_err"}, e.dc ? dc_resp_error_o : ic_resp_error_o, e.err);
      if (e.dc) dc_resp_ready_i = 1'b1; else ic_resp_ready_i = 1'b1;
      step();
      ic_resp_ready_i = 1'b0;
      dc_resp_ready_i = 1'b0;
      chk({tag, "_resp_drop"}, ic_resp_valid_o | dc_resp_valid_o, 0);
    end
  endtask

  initial begin
    logic rr_dc;
    logic exp_dc;
    int   n;
    rst_n = 1'b0;
    ic_req_valid_i = 0; ic_req_addr_i = '0; ic_resp_ready_i = 0;
    dc_req_valid_i = 0; dc_req_addr_i = '0; dc_req_we_i = 0; dc_req_wdata_i = '0; dc_resp_ready_i = 0;
    l2_req_ready_i = 0; l2_resp_valid_i = 0; l2_resp_data_i = '0; l2_resp_error_i = 0;
    step(); step();
    chk("rst_l2_req_valid", l2_req_valid_o, 0);
    chk("rst_l2_resp_ready", l2_resp_ready_o, 0);
    chk("rst_resp_valid", ic_resp_valid_o | dc_resp_valid_o, 0);
    chk("rst_addr", l2_req_addr_o, 0);
    chk("rst_wdata", l2_req_wdata_o, 0);
    rst_n = 1'b1;

    // I-cache refill, minimum latency, address alignment
    l2_req_ready_i = 1; l2_resp_valid_i = 1; l2_resp_data_i = PAT_A5;
    ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_1234;
    #1;
    chk("t1_ic_ready", ic_req_ready_o, 1);
    chk("t1_dc_ready", dc_req_ready_o, 0);
    sb.push_back('{dc: 1'b0, data: PAT_A5, err: 1'b0});
    step();
    ic_req_valid_i = 0; ic_req_addr_i = 32'hFFFF_FFFF;
    chk("t1_req_valid", l2_req_valid_o, 1);
    chk("t1_req_addr", l2_req_addr_o, 32'h0000_1200);
    chk("t1_req_we", l2_req_we_o, 0);
    step();
    chk("t1_wait_ready", l2_resp_ready_o, 1);
    step();
    chk("t1_lat3_valid", ic_resp_valid_o, 1);
    wait_resp("t1");

    // Round-robin from a fresh reset: I, D, I, D
    rst_n = 0; step(); rst_n = 1;
    rr_dc = 1'b1;
    ic_req_valid_i = 1; dc_req_valid_i = 1; dc_req_we_i = 0;
    ic_req_addr_i = 32'h0000_2000; dc_req_addr_i = 32'h0000_3000;
    for (int i = 0; i < 4; i++) begin
      l2_resp_data_i = {16{32'h1000_0000 + 32'(i)}};
      exp_dc = !rr_dc;
      #1;
      chk("t2_ic_ready", ic_req_ready_o, !exp_dc);
      chk("t2_dc_ready", dc_req_ready_o, exp_dc);
      sb.push_back('{dc: exp_dc, data: l2_resp_data_i, err: 1'b0});
      step();
      chk("t2_ready_pulse", ic_req_ready_o | dc_req_ready_o, 0);
      wait_resp("t2");
      rr_dc = exp_dc;
    end
    ic_req_valid_i = 0; dc_req_valid_i = 0;

    // D-cache writeback with L2 back-pressure
    l2_req_ready_i = 0; l2_resp_valid_i = 0;
    dc_req_valid_i = 1; dc_req_we_i = 1; dc_req_addr_i = 32'h8000_0040; dc_req_wdata_i = PAT_WB;
    #1;
    chk("t3_dc_ready", dc_req_ready_o, 1);
    sb.push_back('{dc: 1'b1, data: '0, err: 1'b0});
    step();
    dc_req_valid_i = 0; dc_req_addr_i = 32'h1111_1111; dc_req_wdata_i = '1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", l2_req_valid_o, 1);
      chk("t3_hold_addr", l2_req_addr_o, 32'h8000_0040);
      chk("t3_hold_we", l2_req_we_o, 1);
      chk("t3_hold_wdata", l2_req_wdata_o, PAT_WB);
      step();
    end
    l2_req_ready_i = 1;
    step();
    l2_req_ready_i = 0;
    chk("t3_wait_req_valid", l2_req_valid_o, 0);
    chk("t3_wait_ready", l2_resp_ready_o, 1);
    l2_resp_valid_i = 1; l2_resp_data_i = PAT_A5;
    step();
    l2_resp_valid_i = 0;
    wait_resp("t3");

    // Watchdog: L2 never answers
    l2_req_ready_i = 1;
    ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_4000;
    sb.push_back('{dc: 1'b0, data: '0, err: 1'b1});
    step();
    ic_req_valid_i = 0;
    dc_req_valid_i = 1; dc_req_we_i = 0; dc_req_addr_i = 32'h0000_5000;
    step();
    n = 0;
    while (l2_resp_ready_o && n < 100) begin
      n++;
      step();
    end
    chk("t4_wait_cycles", n, 8);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", ic_resp_valid_o, 1);
      chk("t4_hold_err", ic_resp_error_o, 1);
      chk("t4_no_grant", dc_req_ready_o, 0);
      step();
    end
    wait_resp("t4");
    #1;
    chk("t4_grant_after", dc_req_ready_o, 1);

    // Held D-cache response while the I-cache waits
    sb.push_back('{dc: 1'b1, data: PAT_3C, err: 1'b0});
    step();
    dc_req_valid_i = 0;
    step();
    l2_resp_valid_i = 1; l2_resp_data_i = PAT_3C;
    step();
    l2_resp_valid_i = 0; l2_resp_data_i = '0;
    ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_6000;
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold_valid", dc_resp_valid_o, 1);
      chk("t5_hold_data", dc_resp_data_o, PAT_3C);
      chk("t5_no_grant", ic_req_ready_o, 0);
      step();
    end
    wait_resp("t5");
    #1;
    chk("t5_grant_after", ic_req_ready_o, 1);

    // Reset during WAIT drops the transaction
    step();
    ic_req_valid_i = 0;
    step();
    chk("t6_in_wait", l2_resp_ready_o, 1);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("t6_req_valid", l2_req_valid_o, 0);
    chk("t6_resp_ready", l2_resp_ready_o, 0);
    chk("t6_addr", l2_req_addr_o, 0);
    chk("t6_resp_valid", ic_resp_valid_o | dc_resp_valid_o, 0);
    ic_req_valid_i = 1; dc_req_valid_i = 1;
    #1;
    chk("t6_tie_ic", ic_req_ready_o, 1);
    chk("t6_tie_dc", dc_req_ready_o, 0);
    ic_req_valid_i = 0; dc_req_valid_i = 0; l2_req_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_resp", ic_resp_valid_o | dc_resp_valid_o, 0);
    end
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/l1_l2_refill_arbiter.md
Name: l1_l2_refill_arbiter

Overview:
Arbitrates the single L2 request/response port between the L1 instruction cache (line refills) and the L1 data cache (line refills and dirty writebacks). Allows one outstanding L2 transaction at a time. Grants fairly (round-robin) and routes the 512-bit line response back to the owning requester. A watchdog returns an error if the L2 response never arrives.

Parameters:
ADDR_WIDTH, 32, request address width (line-aligned; bits [5:0] are forced to 0 on output)
LINE_WIDTH, 512, cache line width in bits (64 bytes)
TIMEOUT_CYCLES, 1024, maximum WAIT-state cycles before an error response; legal range 2..65535

Ports:
clk  input  1  clock
rst_n  input  1  active-low reset, synchronous to clk
ic_req_valid_i  input  1  I-cache refill request
ic_req_addr_i  input  ADDR_WIDTH  I-cache line address
ic_req_ready_o  output  1  I-cache request accepted
ic_resp_valid_o  output  1  I-cache response valid
ic_resp_data_o  output  LINE_WIDTH  I-cache refill line
ic_resp_error_o  output  1  I-cache error (L2 error or timeout)
ic_resp_ready_i  input  1  I-cache consumes response
dc_req_valid_i  input  1  D-cache request
dc_req_addr_i  input  ADDR_WIDTH  D-cache line address
dc_req_we_i  input  1  1 = writeback, 0 = refill
dc_req_wdata_i  input  LINE_WIDTH  writeback line
dc_req_ready_o  output  1  D-cache request accepted
dc_resp_valid_o  output  1  D-cache response valid
dc_resp_data_o  output  LINE_WIDTH  D-cache refill line (all zeros for writeback ack)
dc_resp_error_o  output  1  D-cache error
dc_resp_ready_i  input  1  D-cache consumes response
l2_req_valid_o  output  1  request to L2
l2_req_addr_o  output  ADDR_WIDTH  aligned address
l2_req_we_o  output  1  write (writeback)
l2_req_wdata_o  output  LINE_WIDTH  write data
l2_req_ready_i  input  1  L2 accepts request
l2_resp_valid_i  input  1  L2 response valid
l2_resp_data_i  input  LINE_WIDTH  L2 line data
l2_resp_error_i  input  1  L2 error
l2_resp_ready_o  output  1  arbiter accepts L2 response

Behaviour:
- Single clock. rst_n is synchronous and active-low.
- Reset:
  - state = IDLE; rr_last = DC, so the I-cache wins the first tie.
  - All registered outputs = 0, including data buses.
  - Timeout counter = 0.
- Reset mid-transaction drops the transaction silently; no response is issued.
- FSM IDLE -> REQ -> WAIT -> RESP -> IDLE.
- IDLE:
  - ic_req_ready_o and dc_req_ready_o are combinational: high only for the granted requester, only while in IDLE.
  - Grant rule: if only one requester is valid, grant it. If both are valid, grant the one not equal to rr_last.
  - On acceptance (valid && ready): latch owner, addr with [5:0] forced to 0, we (0 for I-cache), and wdata (0 for I-cache); go to REQ.
- REQ:
  - l2_req_valid_o = 1; address, we and wdata are held stable from the latches.
  - Stay in REQ while l2_req_ready_i = 0. The timeout counter does not run here.
  - On l2_req_valid_o && l2_req_ready_i: go to WAIT; counter cleared to 0.
- WAIT:
  - l2_resp_ready_o = 1; counter increments each cycle.
  - On l2_resp_valid_i: capture data (forced to 0 if we = 1) and error; go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: data = 0, error = 1; go to RESP.
  - If a response and the timeout coincide in the same cycle, the response wins with its own error flag.
- RESP:
  - The owner's resp_valid_o = 1 with the captured data/error held stable. The other requester's resp_valid_o stays 0.
  - On resp_valid && resp_ready: rr_last = owner; go to IDLE.
  - New requests are not accepted in RESP; the earliest new grant is the cycle after the handshake.
- l2_req_valid_o, l2_resp_ready_o, *_resp_valid_o are registered and decode directly from state. No combinational path exists from any L2 input to any L2 output.
- Late L2 response (after timeout) arriving in IDLE/REQ: not accepted, since l2_resp_ready_o = 0; the L2 must hold it. This is an L2 protocol violation, flagged by an assertion only.
- Minimum transaction latency, request accept to resp_valid: 3 cycles, with l2_req_ready_i and l2_resp_valid_i both already high.
- Requester addr/wdata may change after acceptance; only the latched copies are used.

Test Plan:
- I-cache only, addr 0x0000_1234; L2 ready immediately and responds 1 cycle later with line 0xA5 pattern -> l2_req_addr_o = 0x0000_1200, we = 0; ic_resp_valid_o with 0xA5 line 3 cycles after accept; dc_resp_valid_o stays 0.
- Both valid every cycle for 4 transactions -> grants I, D, I, D; rr_last alternates; each ready pulse lasts one cycle, in IDLE only.
- D-cache writeback, addr 0x8000_0040, wdata 0xDEAD.. ; l2_req_ready_i low 5 cycles -> l2_req_valid_o held with stable addr/we = 1/wdata for 5 cycles, then WAIT; dc_resp_data_o = 0, error = 0.
- TIMEOUT_CYCLES = 8, L2 never responds -> exactly 8 WAIT cycles, then owner resp_valid with error = 1, data = 0; next request is granted after the handshake.
- Response held with resp_ready_i = 0 for 10 cycles while the other requester is valid -> response data stable throughout, no new grant until the handshake.
- rst_n low for 1 cycle during WAIT -> next cycle state IDLE, all outputs 0, no response emitted; the next tie is granted to the I-cache.
